// File: rtl/rf_wb_arbiter_pkg.sv
// Shared select codes, requester count and the one-hot to mux-select encoder
// for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10
  } sel_e;

  // Input is one-hot or zero; zero maps to A so the mux never sees 2'b11.
  function automatic sel_e onehot_to_sel(input logic [NUM_REQ-1:0] oh);
    sel_e s;
    s = SEL_A;
    if (oh[1]) begin
      s = SEL_B;
    end else if (oh[2]) begin
      s = SEL_C;
    end
    return s;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request/grant bundle between the three requesters and the arbiter.
// The master side drives requests and the stall; the slave (arbiter) drives grant and RF write.
interface rf_wb_arbiter_if #(
  parameter int ADDR_W = 4
);
  import rf_wb_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [ADDR_W-1:0]  addr_a;
  logic [ADDR_W-1:0]  addr_b;
  logic [ADDR_W-1:0]  addr_c;
  logic               wb_hold;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         mux_sel;
  logic               rf_we;
  logic [ADDR_W-1:0]  rf_waddr;
  logic               busy;

  modport master (
    output req, addr_a, addr_b, addr_c, wb_hold,
    input  gnt, mux_sel, rf_we, rf_waddr, busy
  );

  modport slave (
    input  req, addr_a, addr_b, addr_c, wb_hold,
    output gnt, mux_sel, rf_we, rf_waddr, busy
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_pick3.sv
// Combinational 3-way winner picker: searches the eligible vector starting at the
// pointer's requester (round robin) or at A (fixed priority A > B > C). Zero latency.
module rr_pick3
  import rf_wb_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [NUM_REQ-1:0] ptr_i,
  input  logic               rr_en_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               vld_o
);

  logic [NUM_REQ-1:0] start;

  always_comb begin
    win_o = '0;
    start = rr_en_i ? ptr_i : 3'b001;
    case (start)
      3'b010: begin
        if      (elig_i[1]) win_o = 3'b010;
        else if (elig_i[2]) win_o = 3'b100;
        else if (elig_i[0]) win_o = 3'b001;
      end
      3'b100: begin
        if      (elig_i[2]) win_o = 3'b100;
        else if (elig_i[0]) win_o = 3'b001;
        else if (elig_i[1]) win_o = 3'b010;
      end
      default: begin
        if      (elig_i[0]) win_o = 3'b001;
        else if (elig_i[1]) win_o = 3'b010;
        else if (elig_i[2]) win_o = 3'b100;
      end
    endcase
    vld_o = |elig_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter for ALU (A), load (B) and link/imm (C) writebacks.
// req sampled at edge N gives registered gnt/rf_we/mux_sel in cycle N+1; wb_hold blocks new grants.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter bit RR_EN   = 1'b1,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic           clk,
  input  logic           rst_f,
  rf_wb_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ptr_q, ptr_d;
  sel_e               sel_q, sel_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] win;
  logic               win_vld;
  logic [ADDR_W-1:0]  win_addr;

  // Last cycle's grantee still holds req high, so it sits out one arbitration.
  assign elig = bus.req & ~gnt_q;

  rr_pick3 u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .rr_en_i (RR_EN),
    .win_o   (win),
    .vld_o   (win_vld)
  );

  always_comb begin
    case (onehot_to_sel(win))
      SEL_B:   win_addr = bus.addr_b;
      SEL_C:   win_addr = bus.addr_c;
      default: win_addr = bus.addr_a;
    endcase
  end

  always_comb begin
    gnt_d   = '0;
    we_d    = 1'b0;
    sel_d   = sel_q;
    waddr_d = waddr_q;
    ptr_d   = ptr_q;
    if (!bus.wb_hold && win_vld) begin
      gnt_d   = win;
      sel_d   = onehot_to_sel(win);
      waddr_d = win_addr;
      we_d    = !(DROP_R0 && (win_addr == '0));
      // Highest priority moves to the requester after the winner, C wrapping to A.
      ptr_d   = {win[1:0], win[2]};
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      gnt_q   <= '0;
      ptr_q   <= 3'b001;
      sel_q   <= SEL_A;
      we_q    <= 1'b0;
      waddr_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.mux_sel  = sel_q;
  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.busy     = |(bus.req & ~gnt_q);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench: stimulus queues the expected grant per edge, negedge monitors
// compare every grant of a round-robin instance and a fixed-priority instance.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int AW = 4;

  typedef struct packed {
    logic [2:0]    gnt;
    logic [1:0]    sel;
    logic          we;
    logic [AW-1:0] waddr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_f = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t q_rr[$];
  exp_t q_fp[$];

  rf_wb_arbiter_if #(.ADDR_W(AW)) rr_if ();
  rf_wb_arbiter_if #(.ADDR_W(AW)) fp_if ();

  rf_wb_arbiter #(.ADDR_W(AW), .RR_EN(1'b1), .DROP_R0(1'b1)) dut_rr (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (rr_if.slave)
  );

  rf_wb_arbiter #(.ADDR_W(AW), .RR_EN(1'b0), .DROP_R0(1'b1)) dut_fp (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (fp_if.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] g, input logic [1:0] s,
                              input logic w, input logic [AW-1:0] a);
    exp_t e;
    e.gnt = g; e.sel = s; e.we = w; e.waddr = a;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_grant(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%b we=%b waddr=%0d expected gnt=%b sel=%b we=%b waddr=%0d",
               name, act.gnt, act.sel, act.we, act.waddr, exp.gnt, exp.sel, exp.we, exp.waddr);
    end
  endtask

  always @(negedge clk) begin : mon_rr
    exp_t act;
    act = mk(rr_if.gnt, rr_if.mux_sel, rr_if.rf_we, rr_if.rf_waddr);
    if (rr_if.gnt != 3'b000 || rr_if.rf_we) begin
      if (q_rr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_unexpected_grant: got gnt=%b we=%b expected no grant", act.gnt, act.we);
      end else begin
        cmp_grant("rr_grant", act, q_rr.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon_fp
    exp_t act;
    act = mk(fp_if.gnt, fp_if.mux_sel, fp_if.rf_we, fp_if.rf_waddr);
    if (fp_if.gnt != 3'b000 || fp_if.rf_we) begin
      if (q_fp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fp_unexpected_grant: got gnt=%b we=%b expected no grant", act.gnt, act.we);
      end else begin
        cmp_grant("fp_grant", act, q_fp.pop_front());
      end
    end
  end

  // Inputs change 1 time unit after a rising edge and are sampled at the next one.
  task automatic step_rr(input logic [2:0] r, input logic h);
    rr_if.req     = r;
    rr_if.wb_hold = h;
    @(posedge clk);
    #1;
  endtask

  task automatic step_fp(input logic [2:0] r);
    fp_if.req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rr_if.req = 3'b111; rr_if.wb_hold = 1'b0;
    rr_if.addr_a = 4'd3; rr_if.addr_b = 4'd5; rr_if.addr_c = 4'd7;
    fp_if.req = 3'b000; fp_if.wb_hold = 1'b0;
    fp_if.addr_a = 4'd0; fp_if.addr_b = 4'd5; fp_if.addr_c = 4'd7;

    // Reset with all requesting: nothing may be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt",   rr_if.gnt,      3'b000);
    chk("reset_we",    rr_if.rf_we,    1'b0);
    chk("reset_sel",   rr_if.mux_sel,  2'b00);
    chk("reset_waddr", rr_if.rf_waddr, 4'd0);
    chk("reset_busy",  rr_if.busy,     1'b1);
    @(posedge clk);
    #1;
    rst_f = 1'b1;

    // All three requesting, each drops after its grant: A, B, C.
    q_rr.push_back(mk(3'b001, 2'b00, 1'b1, 4'd3)); step_rr(3'b111, 1'b0);
    q_rr.push_back(mk(3'b010, 2'b01, 1'b1, 4'd5)); step_rr(3'b110, 1'b0);
    q_rr.push_back(mk(3'b100, 2'b10, 1'b1, 4'd7)); step_rr(3'b100, 1'b0);
    step_rr(3'b000, 1'b0);

    // Wrap after C: A first, then C.
    q_rr.push_back(mk(3'b001, 2'b00, 1'b1, 4'd3)); step_rr(3'b101, 1'b0);
    q_rr.push_back(mk(3'b100, 2'b10, 1'b1, 4'd7)); step_rr(3'b100, 1'b0);

    // Hold for 4 edges with B waiting.
    for (int i = 0; i < 4; i++) begin
      step_rr(3'b010, 1'b1);
      chk("hold_gnt",  rr_if.gnt,   3'b000);
      chk("hold_we",   rr_if.rf_we, 1'b0);
      chk("hold_busy", rr_if.busy,  1'b1);
    end
    chk("hold_sel_kept",   rr_if.mux_sel,  2'b10);
    chk("hold_waddr_kept", rr_if.rf_waddr, 4'd7);
    q_rr.push_back(mk(3'b010, 2'b01, 1'b1, 4'd5)); step_rr(3'b010, 1'b0);

    // Pointer now after B: C beats A.
    q_rr.push_back(mk(3'b100, 2'b10, 1'b1, 4'd7)); step_rr(3'b101, 1'b0);
    q_rr.push_back(mk(3'b001, 2'b00, 1'b1, 4'd3)); step_rr(3'b001, 1'b0);
    step_rr(3'b000, 1'b0);

    // Write to R0 is granted but suppressed.
    rr_if.addr_a = 4'd0;
    q_rr.push_back(mk(3'b001, 2'b00, 1'b0, 4'd0)); step_rr(3'b001, 1'b0);

    // Async reset in the middle of a B grant cycle.
    q_rr.push_back(mk(3'b010, 2'b01, 1'b1, 4'd5)); step_rr(3'b010, 1'b0);
    @(negedge clk);
    #1;
    rst_f = 1'b0;
    #1;
    chk("async_rst_gnt",   rr_if.gnt,      3'b000);
    chk("async_rst_we",    rr_if.rf_we,    1'b0);
    chk("async_rst_sel",   rr_if.mux_sel,  2'b00);
    chk("async_rst_waddr", rr_if.rf_waddr, 4'd0);
    rr_if.req = 3'b000;
    @(posedge clk);
    #1;
    rst_f = 1'b1;

    // Fixed priority instance.
    q_fp.push_back(mk(3'b001, 2'b00, 1'b0, 4'd0)); step_fp(3'b001);
    step_fp(3'b000);
    q_fp.push_back(mk(3'b010, 2'b01, 1'b1, 4'd5)); step_fp(3'b110);
    q_fp.push_back(mk(3'b001, 2'b00, 1'b0, 4'd0)); step_fp(3'b101);
    q_fp.push_back(mk(3'b100, 2'b10, 1'b1, 4'd7)); step_fp(3'b100);
    step_fp(3'b000);
    step_fp(3'b000);

    @(negedge clk);
    chk("idle_busy_rr",   rr_if.busy,  1'b0);
    chk("idle_busy_fp",   fp_if.busy,  1'b0);
    chk("rr_all_granted", q_rr.size(), 0);
    chk("fp_all_granted", q_fp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Round-robin arbiter for the single register-file write port, shared by three writeback requesters: A = ALU result, B = memory load, C = link/immediate.
- Registers the winner's destination address and write enable. Drives the 2-bit select of the 3-input 32-bit writeback mux, which sits between the requesters' data buses and the register file.
- Uses a req/gnt handshake. Sustains one write per cycle, with stall support from the pipeline controller.

Parameters:
- ADDR_W, 4, register-file address width (16 registers).
- RR_EN, 1, 1 = round-robin priority; 0 = fixed priority A > B > C.
- DROP_R0, 1, 1 = a grant with address 0 completes the handshake but keeps rf_we low.

Ports:
- clk  in  1  system clock, rising edge.
- rst_f  in  1  asynchronous active-low reset.
- req  in  3  write requests; bit0 = A, bit1 = B, bit2 = C.
- addr_a  in  ADDR_W  destination register of A.
- addr_b  in  ADDR_W  destination register of B.
- addr_c  in  ADDR_W  destination register of C.
- wb_hold  in  1  pipeline stall; blocks new grants.
- gnt  out  3  one-hot grant, 1-cycle pulse, registered.
- mux_sel  out  2  writeback mux select: 00 = A, 01 = B, 10 = C. 11 is never driven.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  ADDR_W  register-file write address, registered.
- busy  out  1  high when any req bit is unserviced this cycle.

Behaviour:
- Reset (rst_f low, asynchronous): gnt = 000, mux_sel = 00, rf_we = 0, rf_waddr = 0, priority pointer = A (A highest). The outputs stay at these values while rst_f is low.
- Handshake:
  - A requester asserts req[i] with its address and data stable.
  - It holds all three until it samples gnt[i] = 1.
  - It must deassert req[i] (or present a new request) in the cycle after gnt[i].
- Arbitration happens at every rising edge where wb_hold = 0:
  - Eligible set = req & ~gnt. The just-granted requester is masked for one cycle, because its req is still high.
  - If the eligible set is non-empty: pick the winner, then register gnt[winner] = 1, mux_sel = code(winner), rf_waddr = addr_winner, rf_we = 1.
  - If the eligible set is empty: gnt = 000, rf_we = 0. mux_sel and rf_waddr hold their last values.
- Latency: req asserted in cycle N, sampled at the N/N+1 edge, gives gnt, rf_we and mux_sel in cycle N+1. The register file writes at the N+1/N+2 edge. The requester keeps its data valid through cycle N+1.
- Throughput: one grant per cycle when different requesters alternate. A single requester with req held continuously (a new request each time) gets every other cycle.
- Round robin (RR_EN = 1):
  - Search order starts at the requester after the last winner, wrapping C to A.
  - The pointer updates only on a grant; it does not update on hold or idle cycles.
- Fixed priority (RR_EN = 0): A > B > C. The pointer is unused.
- wb_hold = 1:
  - No new grant; gnt = 000 and rf_we = 0 from the next edge.
  - A grant registered before hold rose still completes in its cycle.
  - The pointer is frozen.
- DROP_R0 = 1 and addr_winner = 0: gnt pulses as normal, rf_we = 0, and the pointer still advances.
- busy = |(req & ~gnt), combinational.
- Simultaneous requests from all three: served in pointer order over 3 consecutive cycles. No requester waits more than 2 grants.
- A req deasserted before its grant (an illegal protocol case): no grant is issued, and it must not corrupt the pointer.
- Reset asserted mid-write: rf_we drops immediately (asynchronously) and the write is lost. Requesters re-request after reset.

Decomposition:
- Shared package:
  - select codes SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10.
  - NUM_REQ = 3.
  - the one-hot-to-select encode function.
- One sub-module, rr_pick3: combinational winner picker. Inputs are the eligible vector, the pointer and RR_EN. Outputs are the one-hot winner and the valid flag.

Test Plan:
- Reset: hold rst_f low with req = 111 → gnt = 000, rf_we = 0, mux_sel = 00, rf_waddr = 0. Release → the first grant is A (gnt = 001, mux_sel = 00).
- All-request fairness: req = 111, addr_a/b/c = 3/5/7, each requester dropping req after its grant → grants A, B, C on consecutive cycles. rf_waddr = 3, 5, 7 and mux_sel = 00, 01, 10.
- Round-robin wrap: last winner C, then req = 101 → A granted. Next cycle only C is eligible → C granted (gnt = 100, mux_sel = 10).
- Hold: req = 010 with wb_hold = 1 for 4 cycles → gnt = 000, rf_we = 0, busy = 1. Drop hold → B is granted the next cycle, and the pointer is unchanged during the hold.
- R0 drop: req = 001, addr_a = 0, DROP_R0 = 1 → gnt = 001, rf_we = 0. Repeat with RR_EN = 0 and req = 110 → B is granted before C.
- Async reset mid-grant: assert rst_f low in the middle of a gnt = 010 cycle → rf_we and gnt go to 0 immediately, without waiting for a clock edge.
